// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: register-mapped pad drive, synchronised/debounced inputs, edge-triggered level irq.
// Optional falling-edge select (EDGE_SEL, sel 5) is built only when GPIO_FALL_IRQ_EN is defined.
module gpio_pad_ctrl #(
  parameter int NPINS  = 16,
  parameter int DB_LEN = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [2:0]       reg_sel,
  input  logic             reg_we,
  input  logic [NPINS-1:0] reg_wdata,
  output logic [NPINS-1:0] reg_rdata,
  input  logic [NPINS-1:0] pad_y,
  output logic [NPINS-1:0] pad_a,
  output logic [NPINS-1:0] pad_en,
  output logic             irq
);

  localparam int CW = $clog2(DB_LEN + 1);

  logic [NPINS-1:0] out_q, out_d;
  logic [NPINS-1:0] oeb_q, oeb_d;
  logic [NPINS-1:0] irq_en_q, irq_en_d;
  logic [NPINS-1:0] stat_q, stat_d;
  logic [NPINS-1:0] filt_dq;
  logic [NPINS-1:0] filt;
  logic [NPINS-1:0] w1c;
  logic [NPINS-1:0] evt;
  logic             irq_q, irq_d;
`ifdef GPIO_FALL_IRQ_EN
  logic [NPINS-1:0] edge_sel_q, edge_sel_d;
`endif

  always_comb begin
    out_d    = out_q;
    oeb_d    = oeb_q;
    irq_en_d = irq_en_q;
    w1c      = '0;
`ifdef GPIO_FALL_IRQ_EN
    edge_sel_d = edge_sel_q;
`endif
    if (reg_we) begin
      case (reg_sel)
        3'd0: out_d    = reg_wdata;
        3'd1: oeb_d    = reg_wdata;
        3'd3: irq_en_d = reg_wdata;
        3'd4: w1c      = reg_wdata;
`ifdef GPIO_FALL_IRQ_EN
        3'd5: edge_sel_d = reg_wdata;
`endif
        default: ;
      endcase
    end
  end

  // A new event overrides a same-cycle W1C so no edge is ever lost.
  always_comb begin
`ifdef GPIO_FALL_IRQ_EN
    evt = ((filt & ~filt_dq) & ~edge_sel_q) | ((~filt & filt_dq) & edge_sel_q);
`else
    evt = filt & ~filt_dq;
`endif
    stat_d = (stat_q & ~w1c) | evt;
    irq_d  = |(stat_q & irq_en_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q    <= '0;
      oeb_q    <= '1;
      irq_en_q <= '0;
      stat_q   <= '0;
      filt_dq  <= '0;
      irq_q    <= 1'b0;
`ifdef GPIO_FALL_IRQ_EN
      edge_sel_q <= '0;
`endif
    end else begin
      out_q    <= out_d;
      oeb_q    <= oeb_d;
      irq_en_q <= irq_en_d;
      stat_q   <= stat_d;
      filt_dq  <= filt;
      irq_q    <= irq_d;
`ifdef GPIO_FALL_IRQ_EN
      edge_sel_q <= edge_sel_d;
`endif
    end
  end

  for (genvar i = 0; i < NPINS; i++) begin : g_pin
    logic          s1_q, s2_q;
    logic          f_q, f_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      f_d   = f_q;
      cnt_d = cnt_q;
      if (s2_q == f_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(DB_LEN - 1)) begin
        f_d   = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        f_q   <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q  <= pad_y[i];
        s2_q  <= s1_q;
        f_q   <= f_d;
        cnt_q <= cnt_d;
      end
    end

    assign filt[i] = f_q;
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_sel)
      3'd0: reg_rdata = out_q;
      3'd1: reg_rdata = oeb_q;
      3'd2: reg_rdata = filt;
      3'd3: reg_rdata = irq_en_q;
      3'd4: reg_rdata = stat_q;
`ifdef GPIO_FALL_IRQ_EN
      3'd5: reg_rdata = edge_sel_q;
`endif
      default: reg_rdata = '0;
    endcase
  end

  assign pad_a  = out_q;
  assign pad_en = oeb_q;
  assign irq    = irq_q;

endmodule
